// File: rtl/ram_rw_ctrl.sv
// Write/read sequencer for a single-port RAM: fill with data = address, then step-read with a dwell.
// Optional macro RD_PAUSE_EN: rd_flag in READ pauses/resumes instead of returning to IDLE.
module ram_rw_ctrl #(
    parameter int              ADDR_W  = 8,
    parameter int              DATA_W  = 8,
    parameter int              CNT_W   = 24,
    parameter logic [CNT_W-1:0] CNT_MAX = CNT_W'(24'd9_999_999)
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              wr_flag,
    input  logic              rd_flag,
    output logic              wr_en,
    output logic              rd_en,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wr_data
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WRITE = 2'd1;
    localparam logic [1:0] READ  = 2'd2;

    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_wr_en;
    logic              r_rd_en;
    logic [DATA_W-1:0] r_wr_data;
`ifdef RD_PAUSE_EN
    logic              r_paused;
    logic              w_paused_nxt;
`endif

    logic [1:0]        w_state_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [DATA_W-1:0] w_wr_data_nxt;
    logic              w_dwell_done;
    logic [CNT_W-1:0]  w_cnt_adv;
    logic [ADDR_W-1:0] w_addr_adv;

    // One read step: hold the address CNT_MAX+1 clocks, then move on (wrapping naturally).
    assign w_dwell_done = (r_cnt == CNT_MAX);
    assign w_cnt_adv    = w_dwell_done ? '0 : r_cnt + CNT_W'(1);
    assign w_addr_adv   = w_dwell_done ? r_addr + ADDR_W'(1) : r_addr;

    generate
        if (DATA_W > ADDR_W) begin : g_data_ext
            assign w_wr_data_nxt = {{(DATA_W-ADDR_W){1'b0}}, w_addr_nxt};
        end else begin : g_data_trunc
            assign w_wr_data_nxt = w_addr_nxt[DATA_W-1:0];
        end
    endgenerate

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_cnt_nxt   = r_cnt;
`ifdef RD_PAUSE_EN
        w_paused_nxt = r_paused;
`endif
        case (r_state)
            IDLE: begin
                if (wr_flag) begin
                    w_state_nxt = WRITE;
                    w_addr_nxt  = '0;
                    w_cnt_nxt   = '0;
                end else if (rd_flag) begin
                    w_state_nxt = READ;
                    w_addr_nxt  = '0;
                    w_cnt_nxt   = '0;
                end
            end
            WRITE: begin
                w_cnt_nxt = '0;
                if (r_addr == ADDR_LAST) begin
                    w_state_nxt = READ;
                    w_addr_nxt  = '0;
                end else begin
                    w_addr_nxt = r_addr + ADDR_W'(1);
                end
            end
            READ: begin
                if (wr_flag) begin
                    w_state_nxt = WRITE;
                    w_addr_nxt  = '0;
                    w_cnt_nxt   = '0;
                end
`ifdef RD_PAUSE_EN
                else if (rd_flag) begin
                    w_paused_nxt = !r_paused;
                end else if (!r_paused) begin
                    w_cnt_nxt  = w_cnt_adv;
                    w_addr_nxt = w_addr_adv;
                end
`else
                else if (rd_flag) begin
                    w_state_nxt = IDLE;
                    w_addr_nxt  = '0;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt  = w_cnt_adv;
                    w_addr_nxt = w_addr_adv;
                end
`endif
            end
            default: begin
                w_state_nxt = IDLE;
                w_addr_nxt  = '0;
                w_cnt_nxt   = '0;
            end
        endcase
`ifdef RD_PAUSE_EN
        // Pause only survives while staying in READ; any entry into READ starts unpaused.
        if (w_state_nxt != READ || r_state != READ) begin
            w_paused_nxt = 1'b0;
        end
`endif
    end

    // NOTE: state registers use non-blocking assignments; the reset is synchronous by design.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_cnt     <= '0;
            r_wr_en   <= 1'b0;
            r_rd_en   <= 1'b0;
            r_wr_data <= '0;
`ifdef RD_PAUSE_EN
            r_paused  <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_addr    <= w_addr_nxt;
            r_cnt     <= w_cnt_nxt;
            r_wr_en   <= (w_state_nxt == WRITE);
            r_rd_en   <= (w_state_nxt == READ);
            r_wr_data <= w_wr_data_nxt;
`ifdef RD_PAUSE_EN
            r_paused  <= w_paused_nxt;
`endif
        end
    end

    assign wr_en   = r_wr_en;
    assign rd_en   = r_rd_en;
    assign addr    = r_addr;
    assign wr_data = r_wr_data;

endmodule
